// File: rtl/apb_master_nslave.sv
// apb_master_nslave: APB3 master bridge, one transfer per valid/ready request, NUM_SLAVES decode.
// Optional macro APB_TIMEOUT_EN aborts ACCESS after TIMEOUT_CYCLES wait states.
`default_nettype none

module apb_master_nslave #(
    parameter int ADDR_W         = 9,
    parameter int DATA_W         = 8,
    parameter int NUM_SLAVES     = 2,
    parameter int SEL_W          = $clog2(NUM_SLAVES),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic [NUM_SLAVES-1:0] PSEL,
    output logic                  PENABLE,
    output logic [ADDR_W-1:0]     PADDR,
    output logic                  PWRITE,
    output logic [DATA_W-1:0]     PWDATA,
    input  logic [DATA_W-1:0]     PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DECERR = 2'd3
    } state_t;

    localparam logic [SEL_W:0] NUM_SLAVES_EXT = (SEL_W+1)'(NUM_SLAVES);
    localparam bit             PARAMS_OK      = (NUM_SLAVES >= 2) && (NUM_SLAVES <= 16) &&
                                                (TIMEOUT_CYCLES >= 1);

    if (!PARAMS_OK) begin : g_bad_params
        $error("apb_master_nslave: NUM_SLAVES must be 2..16 and TIMEOUT_CYCLES >= 1");
    end

    state_t                  state_q;
    logic [NUM_SLAVES-1:0]   psel_q;
    logic                    penable_q;
    logic [ADDR_W-1:0]       paddr_q;
    logic                    pwrite_q;
    logic [DATA_W-1:0]       pwdata_q;
    logic                    rsp_valid_q;
    logic [DATA_W-1:0]       rsp_rdata_q;
    logic                    rsp_err_q;

    logic [SEL_W-1:0]        idx_d;
    logic                    sel_ok_d;
    logic [NUM_SLAVES-1:0]   psel_d;
    logic                    accept_d;
    logic                    tmo_hit_d;

    assign idx_d     = req_addr[ADDR_W-1 -: SEL_W];
    assign sel_ok_d  = ({1'b0, idx_d} < NUM_SLAVES_EXT);
    assign req_ready = (state_q == IDLE) || ((state_q == ACCESS) && PREADY);
    assign accept_d  = req_valid && req_ready;

    always_comb begin
        psel_d = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            psel_d[i] = ({1'b0, idx_d} == (SEL_W+1)'(i));
        end
    end

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] tmo_cnt_q;

    // Cleared during SETUP so the count starts fresh on every ACCESS entry.
    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            tmo_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == ACCESS) && !PREADY) begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
        end
    end

    assign tmo_hit_d = (state_q == ACCESS) && !PREADY &&
                       (tmo_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign tmo_hit_d = 1'b0;
`endif

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q     <= IDLE;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;

            case (state_q)
                SETUP: begin
                    penable_q <= 1'b1;
                    state_q   <= ACCESS;
                end
                ACCESS: begin
                    if (PREADY) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= PSLVERR;
                        rsp_rdata_q <= (pwrite_q || PSLVERR) ? '0 : PRDATA;
                        penable_q   <= 1'b0;
                        if (!accept_d) begin
                            psel_q  <= '0;
                            state_q <= IDLE;
                        end
                    end else if (tmo_hit_d) begin
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        psel_q      <= '0;
                        penable_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                DECERR: begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
                    state_q     <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Acceptance is legal from IDLE and from a completing ACCESS.
            if (accept_d) begin
                paddr_q   <= req_addr;
                pwdata_q  <= req_wdata;
                pwrite_q  <= req_write;
                penable_q <= 1'b0;
                if (sel_ok_d) begin
                    psel_q  <= psel_d;
                    state_q <= SETUP;
                end else begin
                    psel_q  <= '0;
                    state_q <= DECERR;
                end
            end
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_nslave.sv
// tb_apb_master_nslave: directed checks of apb_master_nslave with 2-slave and 3-slave instances.
`default_nettype none

module tb_apb_master_nslave;

    logic       PCLK = 1'b0;
    logic       PRESET;
    always #5 PCLK = ~PCLK;

    // Two-slave instance
    logic       req_valid, req_ready, req_write;
    logic [8:0] req_addr;
    logic [7:0] req_wdata;
    logic       rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic [1:0] PSEL;
    logic       PENABLE, PWRITE;
    logic [8:0] PADDR;
    logic [7:0] PWDATA, PRDATA;
    logic       PREADY, PSLVERR;

    // Three-slave instance
    logic       b_req_valid, b_req_ready, b_req_write;
    logic [8:0] b_req_addr;
    logic [7:0] b_req_wdata;
    logic       b_rsp_valid, b_rsp_err;
    logic [7:0] b_rsp_rdata;
    logic [2:0] b_PSEL;
    logic       b_PENABLE, b_PWRITE;
    logic [8:0] b_PADDR;
    logic [7:0] b_PWDATA, b_PRDATA;
    logic       b_PREADY, b_PSLVERR;

    apb_master_nslave dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    apb_master_nslave #(.NUM_SLAVES(3)) dut3 (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
        .PSEL(b_PSEL), .PENABLE(b_PENABLE), .PADDR(b_PADDR), .PWRITE(b_PWRITE),
        .PWDATA(b_PWDATA), .PRDATA(b_PRDATA), .PREADY(b_PREADY), .PSLVERR(b_PSLVERR)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        PRESET = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;
        b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_PRDATA = '0; b_PREADY = 1'b1; b_PSLVERR = 1'b0;

        // Reset state
        @(negedge PCLK);
        check("rst_psel", PSEL, 0);
        check("rst_penable", PENABLE, 0);
        check("rst_paddr", PADDR, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_req_ready", req_ready, 1);
        PRESET = 1'b0;

        // Write 0xA5 to 0x105, zero wait states
        req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h105; req_wdata = 8'hA5;
        @(negedge PCLK);
        req_valid = 1'b0;
        check("wr_setup_psel", PSEL, 2'b10);
        check("wr_setup_pen", PENABLE, 0);
        check("wr_pwdata", PWDATA, 8'hA5);
        check("wr_paddr", PADDR, 9'h105);
        check("wr_pwrite", PWRITE, 1);
        check("wr_setup_ready", req_ready, 0);
        @(negedge PCLK);
        check("wr_acc_psel", PSEL, 2'b10);
        check("wr_acc_pen", PENABLE, 1);
        check("wr_acc_rsp", rsp_valid, 0);
        @(negedge PCLK);
        check("wr_rsp_valid", rsp_valid, 1);
        check("wr_rsp_err", rsp_err, 0);
        check("wr_rsp_rdata", rsp_rdata, 0);
        check("wr_end_psel", PSEL, 0);
        check("wr_end_pen", PENABLE, 0);
        @(negedge PCLK);
        check("wr_rsp_pulse", rsp_valid, 0);

        // Read 0x012 with three wait states
        PREADY = 1'b0; PRDATA = 8'h3C;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h012;
        @(negedge PCLK);
        req_valid = 1'b0;
        check("rd_setup_psel", PSEL, 2'b01);
        check("rd_setup_pen", PENABLE, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            check("rd_wait_pen", PENABLE, 1);
            check("rd_wait_psel", PSEL, 2'b01);
            check("rd_wait_paddr", PADDR, 9'h012);
            check("rd_wait_pwrite", PWRITE, 0);
            check("rd_wait_ready", req_ready, 0);
            check("rd_wait_rsp", rsp_valid, 0);
        end
        PREADY = 1'b1;
        #1 check("rd_done_ready", req_ready, 1);
        @(negedge PCLK);
        check("rd_rsp_valid", rsp_valid, 1);
        check("rd_rsp_rdata", rsp_rdata, 8'h3C);
        check("rd_rsp_err", rsp_err, 0);

        // Back-to-back write 0x010 then read 0x110
        @(negedge PCLK);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h010; req_wdata = 8'h11;
        @(negedge PCLK);
        check("b2b_setup1_psel", PSEL, 2'b01);
        check("b2b_setup1_ready", req_ready, 0);
        req_write = 1'b0; req_addr = 9'h110;
        @(negedge PCLK);
        check("b2b_acc1_pen", PENABLE, 1);
        check("b2b_acc1_ready", req_ready, 1);
        PRDATA = 8'h5A;
        @(negedge PCLK);
        req_valid = 1'b0;
        check("b2b_rsp1_valid", rsp_valid, 1);
        check("b2b_rsp1_rdata", rsp_rdata, 0);
        check("b2b_setup2_psel", PSEL, 2'b10);
        check("b2b_setup2_pen", PENABLE, 0);
        check("b2b_setup2_pwrite", PWRITE, 0);
        check("b2b_setup2_paddr", PADDR, 9'h110);
        @(negedge PCLK);
        check("b2b_acc2_rsp", rsp_valid, 0);
        check("b2b_acc2_pen", PENABLE, 1);
        @(negedge PCLK);
        check("b2b_rsp2_valid", rsp_valid, 1);
        check("b2b_rsp2_rdata", rsp_rdata, 8'h5A);

        // Slave error on write to slave 0, then a normal read
        @(negedge PCLK);
        PSLVERR = 1'b1;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 9'h020; req_wdata = 8'h66;
        @(negedge PCLK);
        req_valid = 1'b0;
        check("err_psel", PSEL, 2'b01);
        @(negedge PCLK);
        @(negedge PCLK);
        check("err_rsp_valid", rsp_valid, 1);
        check("err_rsp_err", rsp_err, 1);
        check("err_rsp_rdata", rsp_rdata, 0);
        PSLVERR = 1'b0; PRDATA = 8'h77;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h033;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        @(negedge PCLK);
        check("post_err_valid", rsp_valid, 1);
        check("post_err_err", rsp_err, 0);
        check("post_err_rdata", rsp_rdata, 8'h77);

        // Reset asserted mid-ACCESS
        PREADY = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h000;
        @(negedge PCLK);
        req_valid = 1'b0;
        @(negedge PCLK);
        check("mid_rst_pre_pen", PENABLE, 1);
        PRESET = 1'b1;
        #1;
        check("mid_rst_psel", PSEL, 0);
        check("mid_rst_pen", PENABLE, 0);
        check("mid_rst_rsp", rsp_valid, 0);
        @(negedge PCLK);
        PRESET = 1'b0; PREADY = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge PCLK);
            check("mid_rst_no_rsp", rsp_valid, 0);
        end

        // Decode error on the three-slave instance: index 3
        b_req_valid = 1'b1; b_req_write = 1'b0; b_req_addr = 9'h1C0;
        @(negedge PCLK);
        b_req_valid = 1'b0;
        check("dec_psel", b_PSEL, 0);
        check("dec_pen", b_PENABLE, 0);
        check("dec_ready", b_req_ready, 0);
        check("dec_rsp_early", b_rsp_valid, 0);
        @(negedge PCLK);
        check("dec_rsp_valid", b_rsp_valid, 1);
        check("dec_rsp_err", b_rsp_err, 1);
        check("dec_rsp_rdata", b_rsp_rdata, 0);
        check("dec_idle_ready", b_req_ready, 1);

        // Three-slave instance: slave 2 decodes normally
        b_PRDATA = 8'hC3;
        b_req_valid = 1'b1; b_req_addr = 9'h100;
        @(negedge PCLK);
        b_req_valid = 1'b0;
        check("s2_psel", b_PSEL, 3'b100);
        @(negedge PCLK);
        @(negedge PCLK);
        check("s2_rsp_valid", b_rsp_valid, 1);
        check("s2_rsp_rdata", b_rsp_rdata, 8'hC3);
        check("s2_rsp_err", b_rsp_err, 0);

`ifdef APB_TIMEOUT_EN
        // PREADY stuck low: abort after 16 wait cycles
        @(negedge PCLK);
        PREADY = 1'b0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h000;
        @(negedge PCLK);
        req_valid = 1'b0;
        repeat (16) @(negedge PCLK);
        check("tmo_last_pen", PENABLE, 1);
        check("tmo_last_rsp", rsp_valid, 0);
        @(negedge PCLK);
        check("tmo_rsp_valid", rsp_valid, 1);
        check("tmo_rsp_err", rsp_err, 1);
        check("tmo_rsp_rdata", rsp_rdata, 0);
        check("tmo_psel", PSEL, 0);
        check("tmo_pen", PENABLE, 0);
        PREADY = 1'b1;
`endif

        @(negedge PCLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
